// File: rtl/apb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_counter_bank
// Description : APB slave holding NUM_CH independent D_WIDTH-bit counters.
//               Each channel offers up/down counting, a programmable wrap
//               limit, direct load, clear, and a sticky wrap status bit.
//               Channel c occupies 16 bytes at base c*0x10:
//                 +0x0 CTRL   : [0] EN, [1] DIR (1=down), [2] CLR (pulse),
//                               [3] IE (only with CNTBANK_IRQ_EN)
//                 +0x4 COUNT  : read zero-extended, write loads the counter
//                 +0x8 LIMIT  : wrap limit
//                 +0xC STATUS : [0] WRAP sticky, write-1-to-clear
// Options     : define CNTBANK_IRQ_EN to add the per-channel interrupt
//               enable and the registered irq outputs; otherwise irq is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_counter_bank #(
  parameter int NUM_CH     = 4,
  parameter int D_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [NUM_CH-1:0]     irq
);

  localparam int C_CH_W = ADDR_WIDTH - 4;

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_SETUP  = 2'd1;
  localparam logic [1:0] C_ST_ACCESS = 2'd2;

  localparam logic [1:0] C_REG_CTRL   = 2'd0;
  localparam logic [1:0] C_REG_COUNT  = 2'd1;
  localparam logic [1:0] C_REG_LIMIT  = 2'd2;
  localparam logic [1:0] C_REG_STATUS = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_access;

  logic [C_CH_W-1:0]  w_ch;
  logic [1:0]         w_reg;
  logic               w_err;
  logic [31:0]        w_rdata;

  logic [D_WIDTH-1:0] r_cnt      [NUM_CH];
  logic [D_WIDTH-1:0] r_lim      [NUM_CH];
  logic [D_WIDTH-1:0] w_step_cnt [NUM_CH];

  logic [NUM_CH-1:0]  r_en;
  logic [NUM_CH-1:0]  r_dir;
  logic [NUM_CH-1:0]  r_wrap;
  logic [NUM_CH-1:0]  w_ie;
  logic [NUM_CH-1:0]  w_sel;
  logic [NUM_CH-1:0]  w_sw_cnt;
  logic [NUM_CH-1:0]  w_step_wrap;
  logic [NUM_CH-1:0]  w_hw_wrap;

  logic               w_unused;

  // Address decode: channel from the upper bits, register from [3:2].
  // Misaligned addresses and channels beyond NUM_CH are bus errors.
  assign w_ch  = paddr[ADDR_WIDTH-1:4];
  assign w_reg = paddr[3:2];
  assign w_err = (paddr[1:0] != 2'b00) || (32'(w_ch) >= 32'(NUM_CH));

  // Only a subset of the write-data bits is meaningful.
  assign w_unused = ^pwdata;

  // APB protocol state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // APB protocol next-state logic; penable seen from IDLE is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (psel && !penable) w_state_nxt = C_ST_SETUP;
      end
      C_ST_SETUP: begin
        if (!psel)        w_state_nxt = C_ST_IDLE;
        else if (penable) w_state_nxt = C_ST_ACCESS;
      end
      C_ST_ACCESS: begin
        if (psel && !penable) w_state_nxt = C_ST_SETUP;
        else                  w_state_nxt = C_ST_IDLE;
      end
      default: w_state_nxt = C_ST_IDLE;
    endcase
  end

  // APB outputs: zero-wait-state ready and error flag in the access cycle.
  always_comb begin
    w_access = (r_state == C_ST_SETUP) && psel && penable;
    pready   = w_access;
    pslverr  = w_access && w_err;
  end

  // Per-channel write selects and next count value for an enabled step.
  always_comb begin
    w_sel       = '0;
    w_sw_cnt    = '0;
    w_step_wrap = '0;
    w_hw_wrap   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]      = w_access && pwrite && !w_err && (w_ch == C_CH_W'(c));
      // A COUNT load or a CLR pulse overrides this cycle's step.
      w_sw_cnt[c]   = w_sel[c] && ((w_reg == C_REG_COUNT) ||
                                   ((w_reg == C_REG_CTRL) && pwdata[2]));
      w_step_cnt[c] = r_cnt[c];
      if (r_dir[c]) begin
        if (r_cnt[c] == '0) begin
          w_step_cnt[c]  = r_lim[c];
          w_step_wrap[c] = 1'b1;
        end else begin
          w_step_cnt[c]  = r_cnt[c] - D_WIDTH'(1);
        end
      end else begin
        // ">=" so a limit lowered beneath the count wraps on the next step.
        if (r_cnt[c] >= r_lim[c]) begin
          w_step_cnt[c]  = '0;
          w_step_wrap[c] = 1'b1;
        end else begin
          w_step_cnt[c]  = r_cnt[c] + D_WIDTH'(1);
        end
      end
      w_hw_wrap[c] = r_en[c] && w_step_wrap[c] && !w_sw_cnt[c];
    end
  end

  // Counter, limit, control and sticky wrap state for every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
        r_lim[c] <= '1;
      end
      r_en   <= '0;
      r_dir  <= '0;
      r_wrap <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_sel[c] && (w_reg == C_REG_COUNT)) begin
          r_cnt[c] <= pwdata[D_WIDTH-1:0];
        end else if (w_sw_cnt[c]) begin
          r_cnt[c] <= '0;
        end else if (r_en[c]) begin
          r_cnt[c] <= w_step_cnt[c];
        end

        if (w_sel[c] && (w_reg == C_REG_CTRL)) begin
          r_en[c]  <= pwdata[0];
          r_dir[c] <= pwdata[1];
        end

        if (w_sel[c] && (w_reg == C_REG_LIMIT)) begin
          r_lim[c] <= pwdata[D_WIDTH-1:0];
        end

        // A hardware wrap beats a simultaneous software clear.
        if (w_hw_wrap[c]) begin
          r_wrap[c] <= 1'b1;
        end else if (w_sel[c] && (w_reg == C_REG_STATUS) && pwdata[0]) begin
          r_wrap[c] <= 1'b0;
        end
      end
    end
  end

`ifdef CNTBANK_IRQ_EN
  logic [NUM_CH-1:0] r_ie;

  // Interrupt enable bits, written through CTRL bit 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_sel[c] && (w_reg == C_REG_CTRL)) r_ie[c] <= pwdata[3];
      end
    end
  end

  // Registered interrupt: follows WRAP & IE one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= '0;
    end else begin
      irq <= r_wrap & r_ie;
    end
  end

  assign w_ie = r_ie;
`else
  assign w_ie = '0;
  assign irq  = '0;
`endif

  // Read mux for the addressed channel register; unused bits read 0.
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == C_CH_W'(c)) begin
        case (w_reg)
          C_REG_CTRL:  w_rdata = {28'd0, w_ie[c], 1'b0, r_dir[c], r_en[c]};
          C_REG_COUNT: w_rdata = 32'(r_cnt[c]);
          C_REG_LIMIT: w_rdata = 32'(r_lim[c]);
          default:     w_rdata = {31'd0, r_wrap[c]};
        endcase
      end
    end
  end

  // Read data captured in the setup cycle so it is stable during access;
  // it returns to zero once the access cycle is over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata <= '0;
    end else if (psel && !penable && !pwrite && !w_err) begin
      prdata <= w_rdata;
    end else begin
      prdata <= '0;
    end
  end

endmodule
`default_nettype wire
